// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with mid-bit sampling, LSB-first
// data capture, stop-bit validation and a ready/acknowledge byte handshake.
// The 2-flop input synchronizer adds two cycles of latency before any decision.
module uart_rx #(
  parameter int unsigned DW           = 8,
  parameter int unsigned CLOCK        = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned BAUD_COUNTER = CLOCK / BAUD_RATE,
  parameter int unsigned BRW          = $clog2(BAUD_COUNTER + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          rx_i,
  input  logic          rd_ack_i,
  output logic [DW-1:0] data_o,
  output logic          byte_ready_o,
  output logic          done_uart,
  output logic          frame_err_o,
  output logic          overrun_o
);

  localparam int unsigned IW = $clog2(DW + 1);

  // Start bit is validated in its middle; data and stop bits a full bit later.
  localparam logic [BRW-1:0] CNT_HALF = BRW'(BAUD_COUNTER / 2 - 1);
  localparam logic [BRW-1:0] CNT_LAST = BRW'(BAUD_COUNTER - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            sync1;
  logic            rx_s;
  logic [BRW-1:0]  cnt;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   sr;
  logic            at_half;
  logic            at_last;
  logic            bit_tick;
  logic            publish;
  logic            frame_bad;

  // Two-flop synchronizer; idle-high reset keeps the line from looking like a start bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode plus the publish / framing-error strobes.
  always_comb begin
    state_nx  = state;
    publish   = 1'b0;
    frame_bad = 1'b0;
    at_half   = (cnt == CNT_HALF);
    at_last   = (cnt == CNT_LAST);
    bit_tick  = 1'b0;
    if (!cs) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
          end
        end
        START: begin
          if (at_half) begin
            state_nx = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_last) begin
            bit_tick = 1'b1;
            if (idx == IDX_LAST) begin
              state_nx = STOP;
            end
          end
        end
        STOP: begin
          if (at_last) begin
            if (rx_s) begin
              publish  = 1'b1;
              state_nx = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_nx  = BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Baud counter, bit index and shift register. The last data bit is shifted
  // on the same edge that moves to STOP, so the shift is decoupled from the
  // entry-clear of cnt/idx.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
      idx <= '0;
      sr  <= '0;
    end else if (!cs) begin
      cnt <= '0;
      idx <= '0;
      sr  <= '0;
    end else begin
      if (bit_tick) begin
        sr <= {rx_s, sr[DW-1:1]};
      end
      if (state_nx != state) begin
        cnt <= '0;
        idx <= '0;
      end else if (bit_tick) begin
        cnt <= '0;
        idx <= idx + IW'(1);
      end else if (state == START || state == DATA || state == STOP) begin
        cnt <= cnt + BRW'(1);
      end
    end
  end

  // Bus-side status: publish beats a coincident ack, and a framing error
  // beats a coincident ack; overrun only counts an unacknowledged ready byte.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o       <= '0;
      byte_ready_o <= 1'b0;
      done_uart    <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      done_uart <= publish;
      if (publish) begin
        data_o <= sr;
      end
      if (publish) begin
        byte_ready_o <= 1'b1;
      end else if (rd_ack_i) begin
        byte_ready_o <= 1'b0;
      end
      if (frame_bad) begin
        frame_err_o <= 1'b1;
      end else if (rd_ack_i) begin
        frame_err_o <= 1'b0;
      end
      if (rd_ack_i) begin
        overrun_o <= 1'b0;
      end else if (publish && byte_ready_o) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames, hand-written corner sequences and random
// frames checked against a frame-level model of the receiver's status rules.
module tb_uart_rx;

  localparam int unsigned NB = 16;

  logic       clk_i;
  logic       rst_i;
  logic       cs;
  logic       rx_i;
  logic       rd_ack_i;
  logic [7:0] data_o;
  logic       byte_ready_o;
  logic       done_uart;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(
    .DW(8),
    .CLOCK(16),
    .BAUD_RATE(1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cs(cs),
    .rx_i(rx_i),
    .rd_ack_i(rd_ack_i),
    .data_o(data_o),
    .byte_ready_o(byte_ready_o),
    .done_uart(done_uart),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int fall_cyc = 0;
  logic done_prev = 1'b0;

  // Frame-level model state.
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_ovr;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulse-width monitor: every done sample must follow a low sample.
  always @(negedge clk_i) begin
    if (done_uart) begin
      total = total + 1;
      if (done_prev) begin
        bad = bad + 1;
        $display("FAIL done_width act=2+cycles req=1 cycle at cyc=%0d", cyc);
      end
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    done_prev = done_uart;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, "_data"}, 32'(data_o), 32'(m_data));
    chk({name, "_rdy"},  32'(byte_ready_o), 32'(m_rdy));
    chk({name, "_ferr"}, 32'(frame_err_o), 32'(m_ferr));
    chk({name, "_ovr"},  32'(overrun_o), 32'(m_ovr));
  endtask

  task automatic chk_latency(input string name);
    int lat;
    lat = last_done_cyc - fall_cyc;
    total = total + 1;
    if (lat < 154 || lat > 156) begin
      bad = bad + 1;
      $display("FAIL %s act=%0d req=155", name, lat);
    end
  endtask

  // Status rules applied to one whole frame; ack_pub means rd_ack_i landed on
  // the stop-bit sample cycle.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_pub);
    logic was_rdy;
    was_rdy = m_rdy;
    if (ack_pub) begin
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (stop) begin
      if (was_rdy && !ack_pub) m_ovr = 1'b1;
      m_data = d;
      m_rdy  = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_ack();
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Drives line cycles [first,last) of a frame, one per clock, from a negedge.
  // Beyond the ten bit periods the stop level is held (a held-low break).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_pub,
                            input int first, input int last);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    fall_cyc = cyc - first;
    for (int i = first; i < last; i++) begin
      rx_i     = (i < 160) ? bits[i / NB] : stop;
      rd_ack_i = ack_pub && (i == 154);
      @(negedge clk_i);
    end
    rd_ack_i = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic ack_pulse();
    rd_ack_i = 1'b1;
    @(negedge clk_i);
    rd_ack_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ack_pub;
    logic       ack_after;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_ferr;
    logic       e_ovr;
    int         e_done;
  } vec_t;

  vec_t vec [6];

  initial begin
    int d0;
    logic [7:0] rd;
    logic rs, ra;

    vec[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1};
    vec[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 0};
    vec[2] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1};
    vec[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1};
    vec[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1};
    vec[5] = '{8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1};

    rst_i = 1'b0; cs = 1'b1; rx_i = 1'b1; rd_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_rdy",  32'(byte_ready_o), 32'h0);
    chk("rst_done", 32'(done_uart), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_ovr",  32'(overrun_o), 32'h0);
    rst_i = 1'b1;
    idle(5);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      send_frame(vec[k].d, vec[k].stop, vec[k].ack_pub, 0, vec[k].stop ? 160 : 200);
      idle(vec[k].stop ? 4 : 20);
      chk($sformatf("v%0d_data", k), 32'(data_o), 32'(vec[k].e_data));
      chk($sformatf("v%0d_rdy", k),  32'(byte_ready_o), 32'(vec[k].e_rdy));
      chk($sformatf("v%0d_ferr", k), 32'(frame_err_o), 32'(vec[k].e_ferr));
      chk($sformatf("v%0d_ovr", k),  32'(overrun_o), 32'(vec[k].e_ovr));
      chk($sformatf("v%0d_done", k), 32'(done_cnt - d0), 32'(vec[k].e_done));
      if (vec[k].e_done == 1) chk_latency($sformatf("v%0d_latency", k));
      if (vec[k].ack_after) begin
        ack_pulse();
        chk($sformatf("v%0d_ack_rdy", k),  32'(byte_ready_o), 32'h0);
        chk($sformatf("v%0d_ack_ferr", k), 32'(frame_err_o), 32'h0);
        chk($sformatf("v%0d_ack_ovr", k),  32'(overrun_o), 32'h0);
      end
    end
    m_data = 8'h33; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    // Glitch shorter than half a bit: no frame, no flag change.
    d0 = done_cnt;
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    idle(30);
    chk("glitch_done", 32'(done_cnt - d0), 32'h0);
    chk_model("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 0, 160);
    idle(4);
    model_frame(8'h3C, 1'b1, 1'b0);
    chk("glitch_next_done", 32'(done_cnt - d0), 32'h1);
    chk_model("glitch_next");

    // Asynchronous reset in the middle of data bit 3.
    send_frame(8'hF0, 1'b1, 1'b0, 0, 72);
    rst_i = 1'b0;
    #1;
    chk("arst_data", 32'(data_o), 32'h0);
    chk("arst_rdy",  32'(byte_ready_o), 32'h0);
    chk("arst_done", 32'(done_uart), 32'h0);
    chk("arst_ferr", 32'(frame_err_o), 32'h0);
    chk("arst_ovr",  32'(overrun_o), 32'h0);
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    idle(10);
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    // Block disable in the same position: outputs hold, nothing published.
    send_frame(8'hC3, 1'b1, 1'b0, 0, 160);
    idle(4);
    model_frame(8'hC3, 1'b1, 1'b0);
    d0 = done_cnt;
    send_frame(8'hF0, 1'b1, 1'b0, 0, 72);
    cs = 1'b0;
    send_frame(8'hF0, 1'b1, 1'b0, 72, 160);
    idle(10);
    cs = 1'b1;
    idle(5);
    chk("cs_done", 32'(done_cnt - d0), 32'h0);
    chk_model("cs_hold");
    send_frame(8'h81, 1'b1, 1'b0, 0, 160);
    idle(4);
    model_frame(8'h81, 1'b1, 1'b0);
    chk("cs_next_done", 32'(done_cnt - d0), 32'h1);
    chk_model("cs_next");
    ack_pulse();
    model_ack();

    // Random frames against the model.
    for (int r = 0; r < 24; r++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      ra = ($urandom_range(0, 4) == 0);
      d0 = done_cnt;
      send_frame(rd, rs, ra, 0, rs ? 160 : 200);
      idle(rs ? 4 : 20);
      model_frame(rd, rs, ra);
      chk($sformatf("r%0d_done", r), 32'(done_cnt - d0), rs ? 32'h1 : 32'h0);
      chk_model($sformatf("r%0d", r));
      if (rs) chk_latency($sformatf("r%0d_latency", r));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        model_ack();
        chk_model($sformatf("r%0d_ack", r));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
